load_store_unit: RTL and testbench

Sits between the integer datapath and the byte-addressable, big-endian 4096×8 data memory. Adds sub-word access: lb/lbu/lh/lhu/lw loads and sb/sh/sw stores. The memory only moves 4 bytes at a time, so sub-word stores become a read-modify-write of the aligned word, sequenced by a small FSM. Misaligned accesses are flagged and never reach the memory.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_store_unit_if.sv | 30 +++
 rtl/lsu_lane.sv | 61 ++++++
 rtl/load_store_unit.sv | 111 +++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : size encodings, FSM state codes and alignment helper for the LSU
// Rev 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 3'd0;
    localparam lsu_state_t ST_RD    = 3'd1;
    localparam lsu_state_t ST_WR    = 3'd2;
    localparam lsu_state_t ST_FIN   = 3'd3;
    localparam lsu_state_t ST_FAULT = 3'd4;

    // Reserved size 2'b11 falls into the word branch on purpose.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// load_store_unit_if : datapath-side request/response bus of the LSU
// Rev 1.0
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 12
);
    logic              req;
    logic              is_store;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              misaligned;
    logic [31:0]       rdata;

    modport master (
        output req, is_store, size, sign_ext, addr, wdata,
        input  busy, done, misaligned, rdata
    );

    modport slave (
        input  req, is_store, size, sign_ext, addr, wdata,
        output busy, done, misaligned, rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// lsu_lane : big-endian sub-word extract/extend for loads, lane merge for stores
// Rev 1.0
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  wire logic [31:0] word_i,
    input  wire logic [1:0]  off_i,
    input  wire logic [1:0]  size_i,
    input  wire logic        sign_ext_i,
    input  wire logic [31:0] wdata_i,
    output logic      [31:0] load_o,
    output logic      [31:0] merge_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (off_i)
            2'd0:    w_byte = word_i[31:24];
            2'd1:    w_byte = word_i[23:16];
            2'd2:    w_byte = word_i[15:8];
            default: w_byte = word_i[7:0];
        endcase
        w_half = (off_i == 2'd0) ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o = word_i;
        case (size_i)
            SZ_BYTE: load_o = {{24{sign_ext_i & w_byte[7]}}, w_byte};
            SZ_HALF: load_o = {{16{sign_ext_i & w_half[15]}}, w_half};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (off_i)
                    2'd0:    merge_o[31:24] = wdata_i[7:0];
                    2'd1:    merge_o[23:16] = wdata_i[7:0];
                    2'd2:    merge_o[15:8]  = wdata_i[7:0];
                    default: merge_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off_i == 2'd0) merge_o[31:16] = wdata_i[15:0];
                else               merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : sub-word loads/stores over a word-wide big-endian memory;
//                   sub-word stores run as read-modify-write.  Rev 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    load_store_unit_if.slave       bus,
    output logic                   dm_cs_o,
    output logic                   dm_rd_o,
    output logic                   dm_wr_o,
    output logic [ADDR_W-1:0]      dm_addr_o,
    output logic [31:0]            dm_din_o,
    input  wire logic [31:0]       dm_dout_i
);

    lsu_state_t        state_q, state_d;
    logic              is_store_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;

    logic [31:0]       w_lane_word;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;
    logic              w_accept;
    logic              w_subword;

    assign w_accept  = (state_q == ST_IDLE) && bus.req;
    assign w_subword = (bus.size == SZ_BYTE) || (bus.size == SZ_HALF);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (is_misaligned(bus.size, bus.addr[1:0])) state_d = ST_FAULT;
                    else if (!bus.is_store)                     state_d = ST_RD;
                    else if (w_subword)                         state_d = ST_RD;
                    else                                        state_d = ST_WR;
                end
            end
            ST_RD:    state_d = is_store_q ? ST_WR : ST_FIN;
            ST_WR:    state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            is_store_q <= 1'b0;
            size_q     <= SZ_BYTE;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                is_store_q <= bus.is_store;
                size_q     <= bus.size;
                sign_ext_q <= bus.sign_ext;
                addr_q     <= bus.addr;
                wdata_q    <= bus.wdata;
            end
            if (state_q == ST_RD) begin
                word_q <= dm_dout_i;
                if (!is_store_q) rdata_q <= w_load;
            end
        end
    end

    // The load result is written on the RD->FIN edge, so it must come straight
    // from the memory bus; the merge in WR works on the captured word.
    assign w_lane_word = (state_q == ST_RD) ? dm_dout_i : word_q;

    lsu_lane u_lane (
        .word_i     (w_lane_word),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .sign_ext_i (sign_ext_q),
        .wdata_i    (wdata_q),
        .load_o     (w_load),
        .merge_o    (w_merge)
    );

    assign dm_cs_o   = (state_q == ST_RD) || (state_q == ST_WR);
    assign dm_rd_o   = (state_q == ST_RD);
    assign dm_wr_o   = (state_q == ST_WR);
    assign dm_addr_o = dm_cs_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dm_din_o  = dm_wr_o ? w_merge : 32'h0;

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_FIN) || (state_q == ST_FAULT);
    assign bus.misaligned = (state_q == ST_FAULT);
    assign bus.rdata      = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed stimulus with a queue-based response scoreboard
// Rev 1.0
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] din;
        logic [11:0] addr;
        int          done_cyc;
        logic        mis;
        int          nrd;
        int          nwr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        preload;
    logic        dm_cs, dm_rd, dm_wr;
    logic [11:0] dm_addr;
    logic [31:0] dm_din;
    wire  [31:0] dm_dout;
    logic [7:0]  mem [4096];

    int          cyc;
    int          n_cmp;
    int          n_err;
    int          done_total;
    int          wr_total;
    int          nrd, nwr, ncs;
    logic [31:0] last_din;
    logic [11:0] last_addr;
    logic [31:0] lr;
    exp_t        q[$];
    exp_t        em;

    load_store_unit_if #(.ADDR_W(12)) bus ();

    load_store_unit #(.ADDR_W(12)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bus       (bus),
        .dm_cs_o   (dm_cs),
        .dm_rd_o   (dm_rd),
        .dm_wr_o   (dm_wr),
        .dm_addr_o (dm_addr),
        .dm_din_o  (dm_din),
        .dm_dout_i (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Big-endian byte memory, combinational read, write on the clock edge.
    assign dm_dout = (dm_cs && dm_rd)
                   ? {mem[dm_addr], mem[dm_addr + 12'd1], mem[dm_addr + 12'd2], mem[dm_addr + 12'd3]}
                   : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (preload) begin
            mem[12'h010] <= 8'h11; mem[12'h011] <= 8'h22; mem[12'h012] <= 8'h33; mem[12'h013] <= 8'h44;
            mem[12'h020] <= 8'h80; mem[12'h021] <= 8'hFF; mem[12'h022] <= 8'h7F; mem[12'h023] <= 8'h01;
        end else if (dm_cs && dm_wr) begin
            mem[dm_addr]         <= dm_din[31:24];
            mem[dm_addr + 12'd1] <= dm_din[23:16];
            mem[dm_addr + 12'd2] <= dm_din[15:8];
            mem[dm_addr + 12'd3] <= dm_din[7:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: counts strobes per transaction and checks each done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            nrd = 0; nwr = 0; ncs = 0;
        end else begin
            if (dm_cs) begin ncs++; last_addr = dm_addr; end
            if (dm_rd) nrd++;
            if (dm_wr) begin nwr++; wr_total++; last_din = dm_din; end
            if (!dm_cs) chk("idle_din", dm_din, 32'h0);
            if (bus.done) begin
                done_total++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    em = q.pop_front();
                    chk("latency",    cyc,                 em.done_cyc);
                    chk("misaligned", {31'd0, bus.misaligned}, {31'd0, em.mis});
                    chk("rdata",      bus.rdata,           em.rdata);
                    chk("rd_cycles",  nrd,                 em.nrd);
                    chk("wr_cycles",  nwr,                 em.nwr);
                    chk("cs_cycles",  ncs,                 em.nrd + em.nwr);
                    if (em.nrd + em.nwr > 0) chk("dm_addr", {20'd0, last_addr}, {20'd0, em.addr});
                    if (em.nwr > 0)          chk("dm_din",  last_din,  em.din);
                end
                nrd = 0; nwr = 0; ncs = 0;
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic [31:0] din, input int lat, input logic mis,
                         input int erd, input int ewr);
        exp_t e;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.is_store = st; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = wd;
        e.rdata = lr; e.din = din; e.addr = {a[11:2], 2'b00};
        e.done_cyc = cyc + lat; e.mis = mis; e.nrd = erd; e.nwr = ewr;
        q.push_back(e);
        @(posedge clk); #1;
        bus.req = 1'b0;
        drain();
    endtask

    task automatic ld(input logic [1:0] sz, input logic sx, input logic [11:0] a, input logic [31:0] exp);
        lr = exp;
        issue(1'b0, sz, sx, a, 32'h0, 32'h0, 2, 1'b0, 1, 0);
    endtask

    initial begin
        int c;
        int base;
        cyc = 0; n_cmp = 0; n_err = 0; done_total = 0; wr_total = 0;
        nrd = 0; nwr = 0; ncs = 0; last_din = 0; last_addr = 0; lr = 0;
        rst_n = 1'b0; preload = 1'b1;
        bus.req = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 12'h0; bus.wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {31'd0, bus.busy},       32'd0);
        chk("rst_done",  {31'd0, bus.done},       32'd0);
        chk("rst_mis",   {31'd0, bus.misaligned}, 32'd0);
        chk("rst_strb",  {29'd0, dm_cs, dm_rd, dm_wr}, 32'd0);
        chk("rst_addr",  {20'd0, dm_addr},        32'd0);
        chk("rst_din",   dm_din,                  32'd0);
        chk("rst_rdata", bus.rdata,               32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1; preload = 1'b0;

        ld(2'b10, 1'b0, 12'h010, 32'h11223344);
        ld(2'b00, 1'b1, 12'h021, 32'hFFFFFFFF);
        ld(2'b00, 1'b0, 12'h021, 32'h000000FF);
        ld(2'b01, 1'b1, 12'h022, 32'h00007F01);
        ld(2'b01, 1'b1, 12'h020, 32'hFFFF80FF);
        ld(2'b01, 1'b0, 12'h020, 32'h000080FF);
        ld(2'b00, 1'b1, 12'h023, 32'h00000001);
        issue(1'b1, 2'b00, 1'b0, 12'h012, 32'h000000AB, 32'h1122AB44, 3, 1'b0, 1, 1);
        ld(2'b10, 1'b0, 12'h010, 32'h1122AB44);
        issue(1'b1, 2'b01, 1'b0, 12'h022, 32'hCAFE1234, 32'h80FF1234, 3, 1'b0, 1, 1);
        ld(2'b10, 1'b0, 12'h020, 32'h80FF1234);
        issue(1'b1, 2'b10, 1'b0, 12'h030, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b0, 0, 1);
        ld(2'b10, 1'b0, 12'h030, 32'hDEADBEEF);
        issue(1'b1, 2'b01, 1'b0, 12'h011, 32'h0000FFFF, 32'h0, 1, 1'b1, 0, 0);
        issue(1'b0, 2'b10, 1'b0, 12'h013, 32'h0,        32'h0, 1, 1'b1, 0, 0);
        issue(1'b0, 2'b11, 1'b0, 12'h012, 32'h0,        32'h0, 1, 1'b1, 0, 0);

        // Reset during the RD of a half-word store.
        base = wr_total;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.is_store = 1'b1; bus.size = 2'b01; bus.sign_ext = 1'b0;
        bus.addr = 12'h010; bus.wdata = 32'h00005555;
        @(posedge clk); #1;
        bus.req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("arst_done",  {30'd0, bus.done, bus.misaligned}, 32'd0);
        chk("arst_strb",  {29'd0, dm_cs, dm_rd, dm_wr}, 32'd0);
        chk("arst_addr",  {20'd0, dm_addr}, 32'd0);
        chk("arst_din",   dm_din, 32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("arst_no_wr", wr_total - base, 32'd0);
        lr = 32'h0;
        ld(2'b10, 1'b0, 12'h010, 32'h1122AB44);

        // req held high: only IDLE cycles may accept.
        base = done_total;
        @(posedge clk); #1;
        bus.req = 1'b1; bus.is_store = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = 12'h020; bus.wdata = 32'h0;
        c = cyc;
        lr = 32'h80FF1234;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.rdata = lr; e.din = 32'h0; e.addr = 12'h020; e.done_cyc = c + 2 + 3*k;
            e.mis = 1'b0; e.nrd = 1; e.nwr = 0;
            q.push_back(e);
        end
        repeat (7) @(posedge clk);
        #1 bus.req = 1'b0;
        repeat (6) @(posedge clk);
        chk("held_done_count", done_total - base, 32'd3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
